// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO and a busy-based stall request.
// Optional multiply-accumulate (madd/msub) is enabled by defining MD_MADD_EN.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        md_use_D,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MD_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;
`endif

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_n;
  logic [CW-1:0] cnt;
  logic [31:0]   hi_n, lo_n;
  logic [31:0]   res_hi, res_lo;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   divisor, quot_s, rem_s;
  logic          is_long, is_div, accept, commit;

  assign prod_s  = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u  = {32'd0, rs} * {32'd0, rt};
  assign divisor = (rt == 32'd0) ? 32'd1 : rt;

  // The one signed overflow case (most negative / -1) wraps instead of trapping.
  always_comb begin
    quot_s = 32'd0;
    rem_s  = 32'd0;
    if (rs == 32'h8000_0000 && divisor == 32'hFFFF_FFFF) begin
      quot_s = rs;
      rem_s  = 32'd0;
    end else begin
      quot_s = $signed(rs) / $signed(divisor);
      rem_s  = $signed(rs) % $signed(divisor);
    end
  end

  always_comb begin
    res_hi  = hi;
    res_lo  = lo;
    is_long = 1'b0;
    is_div  = 1'b0;
    case (md_op)
      OP_MULT:  begin is_long = 1'b1; {res_hi, res_lo} = prod_s; end
      OP_MULTU: begin is_long = 1'b1; {res_hi, res_lo} = prod_u; end
      OP_DIV: begin
        is_long = 1'b1;
        is_div  = 1'b1;
        if (rt != 32'd0) begin
          res_lo = quot_s;
          res_hi = rem_s;
        end
      end
      OP_DIVU: begin
        is_long = 1'b1;
        is_div  = 1'b1;
        if (rt != 32'd0) begin
          res_lo = rs / divisor;
          res_hi = rs % divisor;
        end
      end
`ifdef MD_MADD_EN
      OP_MADD: begin is_long = 1'b1; {res_hi, res_lo} = {hi, lo} + prod_s; end
      OP_MSUB: begin is_long = 1'b1; {res_hi, res_lo} = {hi, lo} - prod_s; end
`endif
      default: ;
    endcase
  end

  assign accept = (state_q == IDLE) && start && is_long;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (accept) state_n = RUN;
      RUN:     if (cnt == CW'(1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == RUN);
    commit = (state_q == RUN) && (cnt == CW'(1));
  end

  // Results are captured into shadow registers at issue and only exposed at commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= 32'd0;
      lo   <= 32'd0;
      hi_n <= 32'd0;
      lo_n <= 32'd0;
      cnt  <= '0;
    end else begin
      if (accept) begin
        hi_n <= res_hi;
        lo_n <= res_lo;
        cnt  <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (state_q == RUN) begin
        cnt <= cnt - CW'(1);
      end
      if (commit) begin
        hi <= hi_n;
        lo <= lo_n;
      end else if (state_q == IDLE && start && md_op == OP_MTHI) begin
        hi <= rs;
      end else if (state_q == IDLE && start && md_op == OP_MTLO) begin
        lo <= rs;
      end
    end
  end

  assign md_stall = md_use_D & (busy | start);

endmodule
